// File: rtl/dsu_pkg.sv
// Shared types and helpers for the round-robin read arbiter.
package dsu_pkg;

   localparam int MAX_NREQ = 8;

   // One slot of the response tag pipeline: which requester the data belongs to
   // and whether the request fell outside the memory.
   typedef struct packed {
      logic       valid;
      logic [2:0] id;
      logic       err;
   } rsp_tag_t;

   // Index of the set bit of a one-hot vector (OR-reduction, so no priority chain).
   function automatic logic [2:0] onehot2idx(input logic [MAX_NREQ-1:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_NREQ; i++) begin
         if (oh[i]) idx = idx | 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/dsu_rr_arbiter_if.sv
// Requester, response and memory-side signals of one arbiter instance.
//
// Handshake: a request is presented by raising req_valid[i] with req_addr[i]
// and req_lock[i]; it is accepted in the cycle where req_valid[i] & req_ready[i]
// are both high. While req_valid[i]=1 and req_ready[i]=0 the requester keeps its
// inputs stable; lowering req_valid[i] before acceptance withdraws the request.
// rsp_valid is one-hot and carries no ready: responses must be consumed as they
// appear, exactly RD_LAT cycles after acceptance.
interface dsu_rr_arbiter_if #(
   parameter int NREQ = 4,
   parameter int AW   = 17,
   parameter int DW   = 32
);
   logic [NREQ-1:0]       req_mask;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0][31:0] req_addr;
   logic [NREQ-1:0]       req_lock;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       rsp_valid;
   logic [DW-1:0]         rsp_data;
   logic                  rsp_err;
   logic                  mem_rd_en;
   logic [AW-1:0]         mem_rd_addr;
   logic [DW-1:0]         mem_rd_data;
   logic                  busy;

   // Requesters plus memory model side.
   modport master (
      output req_mask, req_valid, req_addr, req_lock, mem_rd_data,
      input  req_ready, rsp_valid, rsp_data, rsp_err, mem_rd_en, mem_rd_addr, busy
   );

   // Arbiter side.
   modport slave (
      input  req_mask, req_valid, req_addr, req_lock, mem_rd_data,
      output req_ready, rsp_valid, rsp_data, rsp_err, mem_rd_en, mem_rd_addr, busy
   );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit of elig at or above ptr, wrapping.
module rr_pick
   import dsu_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0] elig,
   input  logic [2:0]      ptr,
   output logic [NREQ-1:0] gnt,
   output logic [2:0]      gnt_idx,
   output logic            gnt_any
);

   localparam int W2 = 2 * NREQ;
   localparam logic [W2-1:0] ONE = {{(W2-1){1'b0}}, 1'b1};

   logic [W2-1:0]       dbl;
   logic [W2-1:0]       thermo;
   logic [W2-1:0]       masked;
   logic [W2-1:0]       lowest;
   logic [MAX_NREQ-1:0] gnt_wide;

   // Doubling the vector turns the wrapped search into a plain lowest-set-bit pick
   // above ptr; the two halves are folded back into one one-hot grant.
   always_comb begin
      dbl      = {elig, elig};
      thermo   = {W2{1'b1}} << ptr;
      masked   = dbl & thermo;
      lowest   = masked & (~masked + ONE);
      gnt      = lowest[NREQ-1:0] | lowest[W2-1:NREQ];
      gnt_wide = '0;
      gnt_wide[NREQ-1:0] = gnt;
      gnt_idx  = onehot2idx(gnt_wide);
      gnt_any  = |elig;
   end

endmodule

// File: rtl/dsu_rr_arbiter.sv
// Round-robin arbiter of NREQ read requesters onto one single-port memory,
// with per-requester lock, base offset, range check and a tag pipeline that
// steers each read result back to the requester that issued it.
module dsu_rr_arbiter
   import dsu_pkg::*;
#(
   parameter int                 NREQ   = 4,
   parameter int                 AW     = 17,
   parameter int                 DW     = 32,
   parameter int unsigned        DEPTH  = 2**AW,
   parameter int                 RD_LAT = 1,
   parameter logic [NREQ*AW-1:0] BASE   = '0
) (
   input logic              clk,
   input logic              rst_n,
   dsu_rr_arbiter_if.slave  bus
);

   localparam logic [32:0] DEPTH_W = 33'(DEPTH);

   logic [NREQ-1:0] elig;
   logic [NREQ-1:0] gnt;
   logic [2:0]      gnt_idx;
   logic            gnt_any;
   logic [2:0]      ptr_q, ptr_d;
   logic [31:0]     sel_addr;
   logic [AW-1:0]   sel_base;
   logic [32:0]     phys;
   logic            in_range;
   rsp_tag_t        tag_in;
   rsp_tag_t        tag_out;
   rsp_tag_t        tag_d [RD_LAT];
   rsp_tag_t        tag_q [RD_LAT];
   logic [RD_LAT-1:0] stage_vld;
   logic [DW-1:0]   rd_data;

   // Only valid, unmasked requesters compete; nothing is granted while reset is held.
   assign elig = bus.req_valid & bus.req_mask & {NREQ{rst_n}};

   rr_pick #(.NREQ(NREQ)) u_pick (
      .elig    (elig),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   assign bus.req_ready = gnt;

   // Select the winner's address and base with the one-hot grant, range-check the
   // 33-bit sum, drive the memory strobe and build the tag for this cycle.
   always_comb begin
      sel_addr = '0;
      sel_base = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            sel_addr = bus.req_addr[i];
            sel_base = BASE[i*AW +: AW];
         end
      end
      phys            = {1'b0, sel_addr} + 33'(sel_base);
      in_range        = phys < DEPTH_W;
      bus.mem_rd_en   = gnt_any & in_range;
      bus.mem_rd_addr = (gnt_any & in_range) ? phys[AW-1:0] : '0;
      tag_in          = '0;
      tag_in.valid    = gnt_any;
      tag_in.id       = gnt_idx;
      tag_in.err      = gnt_any & ~in_range;
   end

   // Next pointer: a locked winner keeps priority, otherwise start after it.
   always_comb begin
      ptr_d = ptr_q;
      if (gnt_any) begin
         if (|(gnt & bus.req_lock))         ptr_d = gnt_idx;
         else if (gnt_idx == 3'(NREQ - 1)) ptr_d = '0;
         else                               ptr_d = gnt_idx + 3'd1;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

   // Stage inputs: the head takes this cycle's tag (a bubble when idle), the rest shift.
   always_comb begin
      tag_d[0] = tag_in;
      for (int k = 1; k < RD_LAT; k++) tag_d[k] = tag_q[k-1];
   end

   for (genvar k = 0; k < RD_LAT; k++) begin : g_tag
      // Tag stage k; reset flushes in-flight tags so their responses are dropped.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) tag_q[k] <= '0;
         else        tag_q[k] <= tag_d[k];
      end
      assign stage_vld[k] = tag_q[k].valid;
   end

   assign tag_out  = tag_q[RD_LAT-1];
   assign rd_data  = bus.mem_rd_data;
   assign bus.busy = |stage_vld;

   // Response demux: only the tag decides who sees the data; errors return zero.
   always_comb begin
      bus.rsp_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
         bus.rsp_valid[i] = tag_out.valid && (tag_out.id == 3'(i));
      end
      bus.rsp_err  = tag_out.valid & tag_out.err;
      bus.rsp_data = (tag_out.valid && !tag_out.err) ? rd_data : '0;
   end

endmodule
